// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline constants: opcodes, writeback-select encodings and load funct3 values.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        WB_SEL_MEM = 2'b00,
        WB_SEL_ALU = 2'b01,
        WB_SEL_PC4 = 2'b10,
        WB_SEL_RSV = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stores and branches reuse bits [11:7] as immediate, so they never own a destination.
    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode != OP_STORE) && (opcode != OP_BRANCH);
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// Integer register file: one synchronous write port, two combinational read ports that
// forward a same-cycle write, x0 reads as zero.
module rv32_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0)                  ? '0      :
                      (i_we && (i_raddr1 == i_waddr))   ? i_wdata :
                                                          r_regs[i_raddr1];

    assign o_rdata2 = (i_raddr2 == '0)                  ? '0      :
                      (i_we && (i_raddr2 == i_waddr))   ? i_wdata :
                                                          r_regs[i_raddr2];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects and load-formats the writeback value, gates the register write,
// owns the register file with bypassed decode read ports, and counts retired instructions.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wb_sel,
    input  logic             regWEn,
    input  logic [31:0]      instr_wb,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret
);
    import rv32_pkg::*;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [1:0]      w_off;
    logic [7:0]      w_bytes  [4];
    logic [15:0]     w_halves [2];
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_data;
    logic            w_we;
    logic            w_unused;

    logic [CNT_W-1:0] r_instret;

    assign w_opcode = instr_wb[6:0];
    assign w_rd     = instr_wb[11:7];
    assign w_funct3 = instr_wb[14:12];
    assign w_off    = alu_result[1:0];
    assign w_unused = ^instr_wb[31:15];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_bytes[gi] = mem_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_halves
            assign w_halves[gi] = mem_rdata[16*gi +: 16];
        end
    endgenerate

    // Misaligned halfword accesses just use the half picked by off[1]; traps are raised upstream.
    always_comb begin
        w_load = '0;
        w_byte = w_bytes[w_off];
        w_half = w_halves[w_off[1]];
        case (w_funct3)
            F3_LB:   w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   w_load = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  w_load = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   w_load = mem_rdata;
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_data = '0;
        case (wb_sel)
            WB_SEL_MEM: w_data = w_load;
            WB_SEL_ALU: w_data = alu_result;
            WB_SEL_PC4: w_data = pc_plus4;
            default:    w_data = '0;
        endcase
    end

    assign w_we = regWEn & ~rst & (w_rd != 5'd0) & (wb_sel != WB_SEL_RSV) & writes_rd(w_opcode);

    // Every non-bubble retires, including stores, branches and x0 writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (instr_wb != 32'h0) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    rv32_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data)
    );

    assign wb_we   = w_we;
    assign wb_rd   = w_rd;
    assign wb_data = w_data;
    assign instret = r_instret;

endmodule
